// File: rtl/baser_block_lock_ctrl_if.sv
// Block stream into the lock controller and forwarded stream/status out.
// slave = controller side, master = source/sink side.
interface baser_block_lock_ctrl_if #(
  parameter int FRAME_WIDTH = 66
);
  logic                   i_valid;
  logic [FRAME_WIDTH-1:0] i_rx_coded;
  logic [FRAME_WIDTH-1:0] o_rx_coded;
  logic                   o_valid;
  logic                   o_block_lock;
  logic                   o_slip;
  logic [31:0]            o_slip_count;
  logic [31:0]            o_lock_loss_count;
  logic                   o_hi_ber;

  modport slave (
    input  i_valid, i_rx_coded,
    output o_rx_coded, o_valid, o_block_lock, o_slip,
    output o_slip_count, o_lock_loss_count, o_hi_ber
  );

  modport master (
    output i_valid, i_rx_coded,
    input  o_rx_coded, o_valid, o_block_lock, o_slip,
    input  o_slip_count, o_lock_loss_count, o_hi_ber
  );
endinterface

// File: rtl/baser_block_lock_ctrl.sv
// 64B/66B receive block-lock FSM with slip requests and lock statistics.
// Optional hi-BER monitor enabled by defining BASER_LOCK_HI_BER_EN.
module baser_block_lock_ctrl #(
  parameter int DATA_WIDTH       = 64,
  parameter int HDR_WIDTH        = 2,
  parameter int FRAME_WIDTH      = DATA_WIDTH + HDR_WIDTH,
  parameter int SH_CNT_MAX       = 64,
  parameter int INVLD_MAX        = 16,
  parameter int SLIP_WAIT_BLOCKS = 4
`ifdef BASER_LOCK_HI_BER_EN
  ,
  parameter int HIBER_WINDOW     = 1024,
  parameter int HIBER_THRESH     = 97
`endif
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  baser_block_lock_ctrl_if.slave  bus
);

  localparam int SHW = $clog2(SH_CNT_MAX + 1);
  localparam int IVW = $clog2(INVLD_MAX + 1);
  localparam int WTW = (SLIP_WAIT_BLOCKS > 0) ?
                       $clog2(SLIP_WAIT_BLOCKS + 1) : 1;

  typedef enum logic [1:0] {
    TEST_SH   = 2'd0,
    SLIP      = 2'd1,
    SLIP_WAIT = 2'd2
  } state_t;

  state_t                 state, state_d;
  logic [SHW-1:0]         sh_cnt, sh_d, sh_inc;
  logic [IVW-1:0]         invld_cnt, inv_d, inv_inc;
  logic [WTW-1:0]         wait_cnt, wait_d, wait_inc;
  logic                   lock, lock_d, lost;
  logic                   slip_q, valid_q, hib;
  logic [31:0]            slip_cnt, loss_cnt;
  logic [FRAME_WIDTH-1:0] coded_q;
  logic [HDR_WIDTH-1:0]   hdr;
  logic                   good, bad;

  // 01 = control, 10 = data; 00/11 are invalid headers
  assign hdr     = bus.i_rx_coded[HDR_WIDTH-1:0];
  assign good    = (hdr == HDR_WIDTH'(1)) || (hdr == HDR_WIDTH'(2));
  assign bad     = ~good;
  assign sh_inc  = sh_cnt + SHW'(1);
  assign inv_inc = invld_cnt + IVW'(bad);
  assign wait_inc = wait_cnt + WTW'(1);

  always_comb begin
    state_d = state;
    sh_d    = sh_cnt;
    inv_d   = invld_cnt;
    wait_d  = wait_cnt;
    lock_d  = lock;
    lost    = 1'b0;
    unique case (state)
      TEST_SH: begin
        if (bus.i_valid && !lock) begin
          if (bad) begin
            state_d = SLIP;
          end else if (sh_inc == SHW'(SH_CNT_MAX)) begin
            lock_d = 1'b1;
            sh_d   = '0;
            inv_d  = '0;
          end else begin
            sh_d = sh_inc;
          end
        end else if (bus.i_valid) begin
          // loss of lock wins over the window rollover
          if (inv_inc == IVW'(INVLD_MAX)) begin
            lock_d  = 1'b0;
            lost    = 1'b1;
            state_d = SLIP;
          end else if (sh_inc == SHW'(SH_CNT_MAX)) begin
            sh_d  = '0;
            inv_d = '0;
          end else begin
            sh_d  = sh_inc;
            inv_d = inv_inc;
          end
        end
      end
      SLIP: begin
        sh_d    = '0;
        inv_d   = '0;
        wait_d  = '0;
        state_d = (SLIP_WAIT_BLOCKS == 0) ? TEST_SH : SLIP_WAIT;
      end
      SLIP_WAIT: begin
        if (bus.i_valid) begin
          if (wait_inc == WTW'(SLIP_WAIT_BLOCKS)) begin
            wait_d  = '0;
            state_d = TEST_SH;
          end else begin
            wait_d = wait_inc;
          end
        end
      end
      default: state_d = TEST_SH;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= TEST_SH;
      sh_cnt    <= '0;
      invld_cnt <= '0;
      wait_cnt  <= '0;
      lock      <= 1'b0;
      slip_q    <= 1'b0;
      valid_q   <= 1'b0;
      slip_cnt  <= '0;
      loss_cnt  <= '0;
      coded_q   <= '0;
    end else begin
      state     <= state_d;
      sh_cnt    <= sh_d;
      invld_cnt <= inv_d;
      wait_cnt  <= wait_d;
      lock      <= lock_d;
      slip_q    <= (state_d == SLIP);
      valid_q   <= bus.i_valid & lock & ~hib;
      coded_q   <= bus.i_rx_coded;
      if (state == SLIP && slip_cnt != '1)
        slip_cnt <= slip_cnt + 32'd1;
      if (lost && loss_cnt != '1)
        loss_cnt <= loss_cnt + 32'd1;
    end
  end

`ifdef BASER_LOCK_HI_BER_EN
  localparam int HWW = $clog2(HIBER_WINDOW + 1);

  logic [HWW-1:0] hb_cnt, hb_bad, hb_inc, hb_bad_inc;
  logic           hb_blk;

  assign hb_blk     = lock & bus.i_valid & (state == TEST_SH);
  assign hb_inc     = hb_cnt + HWW'(1);
  assign hb_bad_inc = hb_bad + HWW'(bad);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hb_cnt <= '0;
      hb_bad <= '0;
      hib    <= 1'b0;
    end else if (hb_blk && lost) begin
      hb_cnt <= '0;
      hb_bad <= '0;
    end else if (hb_blk) begin
      if (hb_bad_inc >= HWW'(HIBER_THRESH))
        hib <= 1'b1;
      if (hb_inc == HWW'(HIBER_WINDOW)) begin
        if (hb_bad_inc < HWW'(HIBER_THRESH))
          hib <= 1'b0;
        hb_cnt <= '0;
        hb_bad <= '0;
      end else begin
        hb_cnt <= hb_inc;
        hb_bad <= hb_bad_inc;
      end
    end
  end
`else
  assign hib = 1'b0;
`endif

  assign bus.o_rx_coded        = coded_q;
  assign bus.o_valid           = valid_q;
  assign bus.o_block_lock      = lock;
  assign bus.o_slip            = slip_q;
  assign bus.o_slip_count      = slip_cnt;
  assign bus.o_lock_loss_count = loss_cnt;
  assign bus.o_hi_ber          = hib;

endmodule

// File: tb/tb_baser_block_lock_ctrl.sv
// Scoreboard bench for baser_block_lock_ctrl against a block-level lock model.
// Honours BASER_LOCK_HI_BER_EN when the bundle is built with it.
module tb_baser_block_lock_ctrl;

  localparam int FW = 66;
  localparam int SH_MAX = 64;
  localparam int INV_MAX = 16;
  localparam int WAIT_N = 4;
  localparam int HB_WIN = 1024;
  localparam int HB_TH = 97;

  typedef struct {
    int unsigned cyc;
    logic        lock;
    logic        slip;
    logic        valid;
    logic        hib;
    logic [65:0] data;
    logic [31:0] slips;
    logic [31:0] losses;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // behavioural model state
  bit          m_locked;
  bit          m_slip_now;
  bit          m_hib;
  int          m_run;
  int          m_bad;
  int          m_ignore;
  int          m_hb_n;
  int          m_hb_bad;
  logic [31:0] m_slips;
  logic [31:0] m_losses;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  baser_block_lock_ctrl_if #(.FRAME_WIDTH(FW)) bus ();

  baser_block_lock_ctrl dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  function automatic void chk(string name, logic [65:0] act,
                              logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(1, 0) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(1, 0) == 1) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_slip_now = 0; m_hib = 0;
    m_run = 0; m_bad = 0; m_ignore = 0;
    m_hb_n = 0; m_hb_bad = 0;
    m_slips = '0; m_losses = '0;
  endtask

  // drive one cycle, advance the model, queue the expected outputs
  task automatic step(input bit v, input logic [1:0] hdr);
    exp_t e;
    logic [65:0] d;
    bit bad;
    d = {$urandom(), $urandom(), hdr};
    bad = (hdr == 2'b00) || (hdr == 2'b11);
    bus.i_valid = v;
    bus.i_rx_coded = d;
    e.valid = v && m_locked && !m_hib;
    if (m_slip_now) begin
      m_slip_now = 0;
      m_run = 0;
      m_bad = 0;
      m_ignore = WAIT_N;
      if (m_slips != 32'hFFFF_FFFF) m_slips++;
    end else if (v) begin
      if (m_ignore > 0) begin
        m_ignore--;
      end else if (!m_locked) begin
        if (bad) begin
          m_slip_now = 1;
        end else begin
          m_run++;
          if (m_run == SH_MAX) begin
            m_locked = 1; m_run = 0; m_bad = 0;
          end
        end
      end else begin
        m_run++;
        if (bad) m_bad++;
`ifdef BASER_LOCK_HI_BER_EN
        if (m_bad == INV_MAX) begin
          m_hb_n = 0; m_hb_bad = 0;
        end else begin
          m_hb_n++;
          if (bad) m_hb_bad++;
          if (m_hb_bad >= HB_TH) m_hib = 1;
          if (m_hb_n == HB_WIN) begin
            if (m_hb_bad < HB_TH) m_hib = 0;
            m_hb_n = 0; m_hb_bad = 0;
          end
        end
`endif
        if (m_bad == INV_MAX) begin
          m_locked = 0;
          m_slip_now = 1;
          if (m_losses != 32'hFFFF_FFFF) m_losses++;
        end else if (m_run == SH_MAX) begin
          m_run = 0; m_bad = 0;
        end
      end
    end
    e.cyc = cyc + 1;
    e.lock = m_locked;
    e.slip = m_slip_now;
    e.hib = m_hib;
    e.data = d;
    e.slips = m_slips;
    e.losses = m_losses;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("rst_lock", 66'(bus.o_block_lock), 66'd0);
    chk("rst_slip", 66'(bus.o_slip), 66'd0);
    chk("rst_valid", 66'(bus.o_valid), 66'd0);
    chk("rst_hiber", 66'(bus.o_hi_ber), 66'd0);
    chk("rst_data", bus.o_rx_coded, 66'd0);
    chk("rst_slips", 66'(bus.o_slip_count), 66'd0);
    chk("rst_losses", 66'(bus.o_lock_loss_count), 66'd0);
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic goods(input int n);
    for (int i = 0; i < n; i++) step(1'b1, good_hdr());
  endtask

  // one 64-block window with exactly nbad bad headers at random slots
  task automatic window(input int nbad);
    bit pos [SH_MAX];
    int k;
    int p;
    for (int i = 0; i < SH_MAX; i++) pos[i] = 0;
    k = 0;
    while (k < nbad) begin
      p = $urandom_range(SH_MAX - 1, 0);
      if (!pos[p]) begin
        pos[p] = 1;
        k++;
      end
    end
    for (int i = 0; i < SH_MAX; i++)
      step(1'b1, pos[i] ? bad_hdr() : good_hdr());
  endtask

  task automatic soak(input int n, input int badpct);
    bit v;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(99, 0) < 75);
      step(v, ($urandom_range(99, 0) < badpct) ?
              bad_hdr() : good_hdr());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("stale_entry", 66'(q[0].cyc), 66'(cyc));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("lock", 66'(bus.o_block_lock), 66'(e.lock));
        chk("slip", 66'(bus.o_slip), 66'(e.slip));
        chk("valid", 66'(bus.o_valid), 66'(e.valid));
        chk("hiber", 66'(bus.o_hi_ber), 66'(e.hib));
        chk("data", bus.o_rx_coded, e.data);
        chk("slip_count", 66'(bus.o_slip_count), 66'(e.slips));
        chk("loss_count", 66'(bus.o_lock_loss_count), 66'(e.losses));
      end
    end
  end

  initial begin : stim
    bus.i_valid = 1'b0;
    bus.i_rx_coded = '0;
    model_reset();
    @(posedge clk);
    #2;
    do_reset(2);

    // lock after 64 consecutive good headers
    goods(63);
    chk("t1_unlocked_63", 66'(bus.o_block_lock), 66'd0);
    goods(1);
    chk("t1_locked_64", 66'(bus.o_block_lock), 66'd1);
    goods(5);

    // bad header while unlocked, then slip wait and relock
    do_reset(1);
    goods(9);
    step(1'b1, bad_hdr());
    chk("t2_slip_pulse", 66'(bus.o_slip), 66'd1);
    step(1'b1, bad_hdr());
    chk("t2_slip_single", 66'(bus.o_slip), 66'd0);
    chk("t2_slip_count", 66'(bus.o_slip_count), 66'd1);
    for (int i = 0; i < WAIT_N; i++) step(1'b1, bad_hdr());
    goods(63);
    chk("t2_unlocked", 66'(bus.o_block_lock), 66'd0);
    goods(1);
    chk("t2_relocked", 66'(bus.o_block_lock), 66'd1);

    // 15 bad per window keeps lock, 16 drops it
    for (int w = 0; w < 3; w++) window(INV_MAX - 1);
    chk("t3_still_locked", 66'(bus.o_block_lock), 66'd1);
    window(INV_MAX);
    goods(1);
    chk("t3_lost", 66'(bus.o_block_lock), 66'd0);
    chk("t3_loss_count", 66'(bus.o_lock_loss_count), 66'd1);
    chk("t3_slip_count", 66'(bus.o_slip_count), 66'd2);

    // i_valid toggling
    do_reset(1);
    for (int i = 0; i < 2 * SH_MAX - 1; i++)
      step(i % 2 == 0, good_hdr());
    chk("t4_lock_toggle", 66'(bus.o_block_lock), 66'd1);
    chk("t4_no_slips", 66'(bus.o_slip_count), 66'd0);

    // reset while waiting after a slip
    do_reset(1);
    goods(5);
    step(1'b1, bad_hdr());
    step(1'b1, good_hdr());
    goods(2);
    do_reset(3);
    goods(63);
    chk("t5_unlocked", 66'(bus.o_block_lock), 66'd0);
    goods(1);
    chk("t5_locked", 66'(bus.o_block_lock), 66'd1);

    // 97 bad headers spread over a 1024-block hi-BER window
    do_reset(1);
    goods(SH_MAX);
    window(7);
    for (int w = 0; w < 15; w++) window(6);
    step(1'b1, good_hdr());
`ifdef BASER_LOCK_HI_BER_EN
    chk("t6_hiber_set", 66'(bus.o_hi_ber), 66'd1);
    chk("t6_valid_blocked", 66'(bus.o_valid), 66'd0);
`else
    chk("t6_hiber_tied", 66'(bus.o_hi_ber), 66'd0);
`endif
    goods(HB_WIN);
    chk("t6_hiber_clear", 66'(bus.o_hi_ber), 66'd0);

    // random soak at two error rates
    do_reset(1);
    soak(1500, 1);
    soak(1500, 12);
    soak(800, 0);

    for (int i = 0; i < 3; i++) step(1'b0, good_hdr());
    @(negedge clk);
    #1;
    chk("queue_drained", 66'(q.size()), 66'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
